// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arb_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    // Owner/burst state: free arbitration, or one master holding a bounded lock.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Debug owner encoding reported on the owner port.
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    // Map a grant pair onto the owner encoding.
    function automatic logic [1:0] owner_code(input logic gnt0, input logic gnt1);
        if (gnt0) begin
            return OWN_M0;
        end else if (gnt1) begin
            return OWN_M1;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/bus_arb_mux.sv
// Combinational steering of the granted master onto the BUS port, and
// gating of BUS read data back to whichever master holds the grant.
module bus_arb_mux
    import bus_arb_pkg::*;
(
    input  logic              m0_gnt,
    input  logic              m1_gnt,
    input  logic              m0_we,
    input  logic [BUS_AW-1:0] m0_addr,
    input  logic [BUS_DW-1:0] m0_wdata,
    input  logic              m1_we,
    input  logic [BUS_AW-1:0] m1_addr,
    input  logic [BUS_DW-1:0] m1_wdata,
    input  logic [BUS_DW-1:0] bus_rdata,
    output logic              bus_we,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [BUS_DW-1:0] bus_wdata,
    output logic [BUS_DW-1:0] m0_rdata,
    output logic [BUS_DW-1:0] m1_rdata
);

    // Forward the granted master's request; drive zeros when nobody owns the bus.
    always_comb begin
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (m0_gnt) begin
            bus_we    = m0_we;
            bus_addr  = m0_addr;
            bus_wdata = m0_wdata;
        end else if (m1_gnt) begin
            bus_we    = m1_we;
            bus_addr  = m1_addr;
            bus_wdata = m1_wdata;
        end
    end

    // Read data only reaches the master that owns the current beat.
    always_comb begin
        m0_rdata = '0;
        m1_rdata = '0;
        if (m0_gnt) begin
            m0_rdata = bus_rdata;
        end
        if (m1_gnt) begin
            m1_rdata = bus_rdata;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded burst locking.
// Grant is combinational from requests and the registered owner/burst state.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_we,
    input  logic [BUS_AW-1:0] m0_addr,
    input  logic [BUS_DW-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [BUS_DW-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_we,
    input  logic [BUS_AW-1:0] m1_addr,
    input  logic [BUS_DW-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [BUS_DW-1:0] m1_rdata,
    output logic              bus_we,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [BUS_DW-1:0] bus_wdata,
    input  logic [BUS_DW-1:0] bus_rdata,
    output logic [1:0]        owner
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    arb_state_t    state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    logic          beat;
    logic          beat_lock;
    logic [CW-1:0] cnt_inc;

    // Owner/burst state register; last_owner resets to m1 so m0 wins first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Grant: a locking owner keeps the bus while requesting, otherwise round-robin.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (state_q == LOCK0 && m0_req) begin
            m0_gnt = 1'b1;
        end else if (state_q == LOCK1 && m1_req) begin
            m1_gnt = 1'b1;
        end else if (m0_req && m1_req) begin
            if (last_owner_q) begin
                m0_gnt = 1'b1;
            end else begin
                m1_gnt = 1'b1;
            end
        end else if (m0_req) begin
            m0_gnt = 1'b1;
        end else if (m1_req) begin
            m1_gnt = 1'b1;
        end
    end

    // Next-state: cnt_inc is the beat count including the current beat, so the
    // release fires on the beat that reaches MAX_BURST (MAX_BURST=1 never locks).
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        beat         = m0_gnt | m1_gnt;
        beat_lock    = m0_gnt ? m0_lock : m1_lock;
        cnt_inc      = (state_q == IDLE) ? CW'(1) : burst_cnt_q + 1'b1;

        if (beat) begin
            last_owner_d = m1_gnt;
        end

        case (state_q)
            IDLE: begin
                if (beat && beat_lock && cnt_inc < CNT_MAX) begin
                    state_d     = m1_gnt ? LOCK1 : LOCK0;
                    burst_cnt_d = cnt_inc;
                end else begin
                    burst_cnt_d = '0;
                end
            end
            LOCK0: begin
                if (m0_req && m0_lock && cnt_inc < CNT_MAX) begin
                    burst_cnt_d = cnt_inc;
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            end
            LOCK1: begin
                if (m1_req && m1_lock && cnt_inc < CNT_MAX) begin
                    burst_cnt_d = cnt_inc;
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    assign owner = owner_code(m0_gnt, m1_gnt);

    bus_arb_mux u_mux (
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .bus_rdata (bus_rdata),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata)
    );

    // Grants are exclusive and never issued without a request.
    always_ff @(posedge clk) begin
        assert (!(m0_gnt && m1_gnt));
        assert (!(m0_gnt && !m0_req) && !(m1_gnt && !m1_req));
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: directed scenarios plus constrained-random traffic,
// compared against an owner/beat-count reference model for two instances
// (MAX_BURST=8 driving a small memory, MAX_BURST=1 sharing the same masters).
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_lock, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_lock, m1_we;
    logic [31:0] m1_addr, m1_wdata;

    logic        m0_gnt, m1_gnt, bus_we;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  owner;

    logic        m0_gnt_b, m1_gnt_b, bus_we_b;
    logic [31:0] m0_rdata_b, m1_rdata_b, bus_addr_b, bus_wdata_b;
    logic [31:0] bus_rdata_b;
    logic [1:0]  owner_b;

    int errors = 0;
    int checks = 0;

    // Bus-side memory seen by the main instance.
    logic [31:0] mem [256] = '{default: '0};
    assign bus_rdata   = mem[bus_addr[9:2]];
    assign bus_rdata_b = 32'hCAFE_F00D;
    always @(posedge clk) if (bus_we) mem[bus_addr[9:2]] <= bus_wdata;

    bus_arbiter #(.MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .owner(owner)
    );

    bus_arbiter #(.MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt_b), .m0_rdata(m0_rdata_b),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt_b), .m1_rdata(m1_rdata_b),
        .bus_we(bus_we_b), .bus_addr(bus_addr_b), .bus_wdata(bus_wdata_b),
        .bus_rdata(bus_rdata_b), .owner(owner_b)
    );

    // Reference model per instance: lock holder (-1 none), beats in the
    // current lock, last granted master, burst limit.
    int lk [2] = '{-1, -1};
    int bc [2] = '{0, 0};
    int lo [2] = '{1, 1};
    int mx [2] = '{8, 1};
    logic [31:0] emem [256] = '{default: '0};

    function automatic logic req_of(int m);
        return (m == 1) ? m1_req : m0_req;
    endfunction

    function automatic logic lock_of(int m);
        return (m == 1) ? m1_lock : m0_lock;
    endfunction

    // Expected owner code for instance k from the arbitration rules.
    function automatic logic [1:0] mgnt(int k);
        if (lk[k] >= 0 && req_of(lk[k])) return (lk[k] == 0) ? 2'b01 : 2'b10;
        if (m0_req && m1_req) return (lo[k] == 1) ? 2'b01 : 2'b10;
        if (m0_req) return 2'b01;
        if (m1_req) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] addr_sel(logic [1:0] g);
        return (g == 2'b01) ? m0_addr : (g == 2'b10) ? m1_addr : 32'h0;
    endfunction

    function automatic logic [31:0] wdata_sel(logic [1:0] g);
        return (g == 2'b01) ? m0_wdata : (g == 2'b10) ? m1_wdata : 32'h0;
    endfunction

    function automatic logic we_sel(logic [1:0] g);
        return (g == 2'b01) ? m0_we : (g == 2'b10) ? m1_we : 1'b0;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic commit();
        for (int k = 0; k < 2; k++) begin
            logic [1:0]  g;
            logic [31:0] a;
            int          w;
            g = mgnt(k);
            w = (g == 2'b01) ? 0 : (g == 2'b10) ? 1 : -1;
            if (k == 0 && w >= 0 && we_sel(g)) begin
                a = addr_sel(g);
                emem[a[9:2]] = wdata_sel(g);
            end
            if (rst) begin
                lk[k] = -1; bc[k] = 0; lo[k] = 1;
            end else begin
                if (w >= 0) lo[k] = w;
                if (lk[k] >= 0 && !req_of(lk[k])) begin
                    lk[k] = -1; bc[k] = 0;
                end else if (w >= 0 && lock_of(w)) begin
                    bc[k] = bc[k] + 1;
                    if (bc[k] >= mx[k]) begin lk[k] = -1; bc[k] = 0; end
                    else lk[k] = w;
                end else begin
                    lk[k] = -1; bc[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1;
        tick(); tick();
        rst = 0;
        #2;
        checks++;
        if ({m0_gnt, m1_gnt, bus_we, owner} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got gnt0=%b gnt1=%b we=%b owner=%b expected all 0", m0_gnt, m1_gnt, bus_we, owner);
        end
        checks++;
        if ({bus_addr, bus_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h r0=%h r1=%h expected 0", bus_addr, bus_wdata, m0_rdata, m1_rdata);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.burst_cnt_q !== 4'd0 || dut.last_owner_q !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got state=%0d cnt=%0d last=%b expected 0 0 1", dut.state_q, dut.burst_cnt_q, dut.last_owner_q);
        end
    endtask

    task automatic test_alternate();
        logic [1:0]  exp;
        logic [31:0] ea;
        idle_all();
        m0_req = 1; m0_addr = 32'h0000_0100;
        m1_req = 1; m1_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            #2;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            ea  = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            checks++;
            if (owner !== exp || bus_addr !== ea) begin
                errors++;
                $display("FAIL alt cycle %0d: got owner=%b addr=%h expected %b %h", i, owner, bus_addr, exp, ea);
            end
            checks++;
            if (owner_b !== exp) begin
                errors++;
                $display("FAIL alt_b cycle %0d: got owner=%b expected %b", i, owner_b, exp);
            end
            tick();
        end
    endtask

    task automatic test_burst_limit();
        logic [1:0] exp_b;
        idle_all();
        m0_req = 1; m0_addr = 32'h10;
        tick();
        m1_req = 1; m1_lock = 1; m1_addr = 32'h20;
        for (int i = 1; i <= 9; i++) begin
            #2;
            checks++;
            if (m1_gnt !== (i <= 8) || m0_gnt !== (i == 9)) begin
                errors++;
                $display("FAIL burst cycle %0d: got gnt0=%b gnt1=%b expected %b %b", i, m0_gnt, m1_gnt, (i == 9), (i <= 8));
            end
            exp_b = (i % 2 == 1) ? 2'b10 : 2'b01;
            checks++;
            if (owner_b !== exp_b) begin
                errors++;
                $display("FAIL burst_max1 cycle %0d: got owner=%b expected %b", i, owner_b, exp_b);
            end
            tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_write_read();
        idle_all();
        m0_req = 1; m0_we = 1; m0_addr = 32'h0000_4010; m0_wdata = 32'h1234_5678;
        #2;
        checks++;
        if (m0_gnt !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h0000_4010 || bus_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write: got gnt0=%b we=%b addr=%h wdata=%h expected 1 1 00004010 12345678", m0_gnt, bus_we, bus_addr, bus_wdata);
        end
        tick();
        idle_all();
        m1_req = 1; m1_addr = 32'h0000_4010;
        #2;
        checks++;
        if (m1_gnt !== 1'b1 || m1_rdata !== 32'h1234_5678 || m0_rdata !== 32'h0 || bus_we !== 1'b0) begin
            errors++;
            $display("FAIL read: got gnt1=%b r1=%h r0=%h we=%b expected 1 12345678 0 0", m1_gnt, m1_rdata, m0_rdata, bus_we);
        end
        tick();
        idle_all();
    endtask

    task automatic test_lock_drop();
        idle_all();
        m0_req = 1; m0_lock = 1; m0_addr = 32'h40;
        tick(); tick(); tick();
        checks++;
        if (dut.state_q !== LOCK0 || dut.burst_cnt_q !== 4'd3) begin
            errors++;
            $display("FAIL lock_cnt: got state=%0d cnt=%0d expected LOCK0 3", dut.state_q, dut.burst_cnt_q);
        end
        m0_req = 0; m0_lock = 0;
        m1_req = 1; m1_addr = 32'h80;
        #2;
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || bus_addr !== 32'h80) begin
            errors++;
            $display("FAIL lock_drop: got gnt0=%b gnt1=%b addr=%h expected 0 1 00000080", m0_gnt, m1_gnt, bus_addr);
        end
        tick();
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL lock_drop_state: got state=%0d expected IDLE", dut.state_q);
        end
        idle_all();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        idle_all();
        m1_req = 1; m1_lock = 1; m1_addr = 32'h44;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (dut.state_q !== LOCK1 || dut.burst_cnt_q !== 4'd5) begin
            errors++;
            $display("FAIL rst_pre: got state=%0d cnt=%0d expected LOCK1 5", dut.state_q, dut.burst_cnt_q);
        end
        m0_req = 1; m0_addr = 32'h48;
        rst = 1;
        #2;
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_during: got gnt0=%b gnt1=%b expected 0 1", m0_gnt, m1_gnt);
        end
        tick();
        rst = 0;
        #2;
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || dut.burst_cnt_q !== 4'd0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL rst_after: got gnt0=%b gnt1=%b cnt=%0d state=%0d expected 1 0 0 IDLE", m0_gnt, m1_gnt, dut.burst_cnt_q, dut.state_q);
        end
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_idle();
        idle_all();
        for (int i = 0; i < 10; i++) begin
            #2;
            checks++;
            if (bus_we !== 1'b0 || bus_addr !== 32'h0 || owner !== OWN_NONE) begin
                errors++;
                $display("FAIL idle cycle %0d: got we=%b addr=%h owner=%b expected 0 0 00", i, bus_we, bus_addr, owner);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [1:0]  ga, gb;
        logic [31:0] ea;
        logic        hold0, hold1;
        hold0 = 0; hold1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hold0) begin
                m0_req = ($urandom_range(0, 3) != 0); m0_lock = $urandom_range(0, 1);
                m0_we = $urandom_range(0, 1); m0_addr = $urandom & 32'h0000_03FC; m0_wdata = $urandom;
            end
            if (!hold1) begin
                m1_req = ($urandom_range(0, 3) != 0); m1_lock = $urandom_range(0, 1);
                m1_we = $urandom_range(0, 1); m1_addr = $urandom & 32'h0000_03FC; m1_wdata = $urandom;
            end
            #2;
            ga = mgnt(0);
            gb = mgnt(1);
            ea = addr_sel(ga);
            checks++;
            if (owner !== ga || {m1_gnt, m0_gnt} !== ga) begin
                errors++;
                $display("FAIL rnd_owner cycle %0d: got owner=%b gnt=%b%b expected %b", i, owner, m1_gnt, m0_gnt, ga);
            end
            checks++;
            if (bus_addr !== ea || bus_we !== we_sel(ga) || bus_wdata !== wdata_sel(ga)) begin
                errors++;
                $display("FAIL rnd_bus cycle %0d: got addr=%h we=%b wdata=%h expected %h %b %h", i, bus_addr, bus_we, bus_wdata, ea, we_sel(ga), wdata_sel(ga));
            end
            checks++;
            if (m0_rdata !== ((ga == 2'b01) ? emem[ea[9:2]] : 32'h0) || m1_rdata !== ((ga == 2'b10) ? emem[ea[9:2]] : 32'h0)) begin
                errors++;
                $display("FAIL rnd_rdata cycle %0d: got r0=%h r1=%h expected data %h for owner %b", i, m0_rdata, m1_rdata, emem[ea[9:2]], ga);
            end
            checks++;
            if (owner_b !== gb || {m1_gnt_b, m0_gnt_b} !== gb || bus_addr_b !== addr_sel(gb) || bus_we_b !== we_sel(gb) ||
                bus_wdata_b !== wdata_sel(gb) || m0_rdata_b !== ((gb == 2'b01) ? 32'hCAFE_F00D : 32'h0) ||
                m1_rdata_b !== ((gb == 2'b10) ? 32'hCAFE_F00D : 32'h0)) begin
                errors++;
                $display("FAIL rnd_max1 cycle %0d: got owner=%b addr=%h expected %b %h", i, owner_b, bus_addr_b, gb, addr_sel(gb));
            end
            hold0 = m0_req && (ga != 2'b01);
            hold1 = m1_req && (ga != 2'b10);
            tick();
        end
        idle_all();
        tick();
    endtask

    initial begin
        rst = 1;
        idle_all();
        #1;
        test_reset();
        test_alternate();
        test_burst_limit();
        test_write_read();
        test_lock_drop();
        test_reset_mid_burst();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
